// File: rtl/vram1_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram1_arbiter
// Brief    : Video/CPU arbiter and sequencer for one 4096x8 synchronous-read
//            VRAM bank. Optional CPU starvation guard: VRAM1_ARB_STARVE_GUARD_EN
// Revision : 1.0  initial release
// ============================================================================
module vram1_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        i_MCLK,
    input  logic        i_RST,
    input  logic        i_VID_REQ,
    input  logic [11:0] i_VID_ADDR,
    output logic        o_VID_RDY,
    output logic [7:0]  o_VID_DATA,
    output logic        o_VID_VALID,
    input  logic        i_CPU_REQ,
    input  logic        i_CPU_WE,
    input  logic [11:0] i_CPU_ADDR,
    input  logic [7:0]  i_CPU_DIN,
    output logic [7:0]  o_CPU_DOUT,
    output logic        o_CPU_ACK,
    output logic [11:0] o_RAM_ADDR,
    output logic [7:0]  o_RAM_DIN,
    output logic        o_RAM_WR_n,
    output logic        o_RAM_RD_n,
    input  logic [7:0]  i_RAM_DOUT
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_ACK   = 3'd3,
        S_HOLD  = 3'd4
    } cpu_state_t;

    cpu_state_t r_state;
    cpu_state_t w_state_nxt;

    logic       w_cpu_pend;
    logic       w_force;
    logic       w_vid_grant;
    logic       w_cpu_grant;
    logic [1:0] r_vid_pipe;
    logic       r_cpu_we;

    assign w_cpu_pend = (r_state == S_IDLE) && i_CPU_REQ;

`ifdef VRAM1_ARB_STARVE_GUARD_EN
    logic [7:0] r_starve_cnt;

    assign w_force = w_cpu_pend && (r_starve_cnt == 8'(STARVE_LIMIT));

    // Counts edges a waiting CPU has lost to video; saturates at 255.
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            r_starve_cnt <= 8'd0;
        end else if (!w_cpu_pend || w_cpu_grant) begin
            r_starve_cnt <= 8'd0;
        end else if (r_starve_cnt != 8'hFF) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end
`else
    logic w_unused_limit;

    assign w_unused_limit = ^8'(STARVE_LIMIT);
    assign w_force        = 1'b0;
`endif

    assign o_VID_RDY   = ~w_force;
    assign w_vid_grant = i_VID_REQ && o_VID_RDY;
    assign w_cpu_grant = w_cpu_pend && !w_vid_grant;

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // HOLD waits for REQ to drop so one held request yields one access.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cpu_grant) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_ACK;
            S_ACK:   w_state_nxt = S_HOLD;
            S_HOLD:  if (!i_CPU_REQ) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            o_RAM_ADDR  <= 12'd0;
            o_RAM_DIN   <= 8'd0;
            o_RAM_WR_n  <= 1'b1;
            o_RAM_RD_n  <= 1'b1;
            r_cpu_we    <= 1'b0;
            r_vid_pipe  <= 2'b00;
            o_VID_VALID <= 1'b0;
            o_VID_DATA  <= 8'd0;
            o_CPU_ACK   <= 1'b0;
            o_CPU_DOUT  <= 8'd0;
        end else begin
            o_RAM_WR_n <= ~(w_cpu_grant && i_CPU_WE);
            o_RAM_RD_n <= ~(w_vid_grant || (w_cpu_grant && !i_CPU_WE));
            if (w_vid_grant) begin
                o_RAM_ADDR <= i_VID_ADDR;
            end else if (w_cpu_grant) begin
                o_RAM_ADDR <= i_CPU_ADDR;
                o_RAM_DIN  <= i_CPU_DIN;
                r_cpu_we   <= i_CPU_WE;
            end

            // Read data appears one edge after the strobe edge; capture one later.
            r_vid_pipe  <= {r_vid_pipe[0], w_vid_grant};
            o_VID_VALID <= r_vid_pipe[1];
            if (r_vid_pipe[1]) begin
                o_VID_DATA <= i_RAM_DOUT;
            end

            o_CPU_ACK <= (r_state == S_WAIT);
            if ((r_state == S_WAIT) && !r_cpu_we) begin
                o_CPU_DOUT <= i_RAM_DOUT;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram1_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram1_arbiter
// Brief    : Scoreboard bench for vram1_arbiter with an SRAM model and a
//            transaction-level reference of arbitration and memory contents.
// Revision : 1.0  initial release
// ============================================================================
module tb_vram1_arbiter;

`ifdef VRAM1_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_VID_REQ = 1'b0;
    logic [11:0] i_VID_ADDR = 12'd0;
    logic        o_VID_RDY;
    logic [7:0]  o_VID_DATA;
    logic        o_VID_VALID;
    logic        i_CPU_REQ = 1'b0;
    logic        i_CPU_WE = 1'b0;
    logic [11:0] i_CPU_ADDR = 12'd0;
    logic [7:0]  i_CPU_DIN = 8'd0;
    logic [7:0]  o_CPU_DOUT;
    logic        o_CPU_ACK;
    logic [11:0] o_RAM_ADDR;
    logic [7:0]  o_RAM_DIN;
    logic        o_RAM_WR_n;
    logic        o_RAM_RD_n;
    logic [7:0]  i_RAM_DOUT = 8'd0;

    int total = 0;
    int bad   = 0;

    vram1_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_MCLK(clk), .i_RST(rst),
        .i_VID_REQ(i_VID_REQ), .i_VID_ADDR(i_VID_ADDR), .o_VID_RDY(o_VID_RDY),
        .o_VID_DATA(o_VID_DATA), .o_VID_VALID(o_VID_VALID),
        .i_CPU_REQ(i_CPU_REQ), .i_CPU_WE(i_CPU_WE), .i_CPU_ADDR(i_CPU_ADDR),
        .i_CPU_DIN(i_CPU_DIN), .o_CPU_DOUT(o_CPU_DOUT), .o_CPU_ACK(o_CPU_ACK),
        .o_RAM_ADDR(o_RAM_ADDR), .o_RAM_DIN(o_RAM_DIN), .o_RAM_WR_n(o_RAM_WR_n),
        .o_RAM_RD_n(o_RAM_RD_n), .i_RAM_DOUT(i_RAM_DOUT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input logic [11:0] a);
        if (a < 12'd3) return 8'hA0 + a[7:0];
        return a[7:0] ^ {a[11:8], a[11:8]};
    endfunction

    // SRAM model: registered read, write on strobe edge
    logic [7:0] sram   [4096];
    bit         sram_w [4096];
    always @(posedge clk) begin
        if (!o_RAM_RD_n) i_RAM_DOUT <= sram_w[o_RAM_ADDR] ? sram[o_RAM_ADDR] : init_val(o_RAM_ADDR);
        if (!o_RAM_WR_n) begin
            sram[o_RAM_ADDR]   <= o_RAM_DIN;
            sram_w[o_RAM_ADDR] <= 1'b1;
        end
    end

    // Reference model: shadow memory plus the arbitration rules, one slot per edge
    typedef struct { logic [7:0] d; int due; } exp_t;
    exp_t       vq[$];
    exp_t       cq[$];
    logic [7:0] sh  [4096];
    bit         shw [4096];
    int         cyc = 0;
    bit         m_idle = 1'b1;
    int         m_starve = 0;
    int         m_free = 0;
    logic [7:0] m_dout = 8'd0;
    bit         pend, frc, vacc, cgr;
    exp_t       e;

    function automatic logic [7:0] sh_rd(input logic [11:0] a);
        return shw[a] ? sh[a] : init_val(a);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            vq.delete();
            cq.delete();
            m_idle   = 1'b1;
            m_starve = 0;
            m_dout   = 8'd0;
        end else begin
            cyc++;
            pend = m_idle && i_CPU_REQ;
            frc  = GUARD && pend && (m_starve == LIMIT);
            vacc = i_VID_REQ && !frc;
            cgr  = pend && !vacc;
            if (!m_idle && cyc >= m_free && !i_CPU_REQ) m_idle = 1'b1;
            if (vacc) begin
                e.d = sh_rd(i_VID_ADDR);
                e.due = cyc + 2;
                vq.push_back(e);
            end
            if (cgr) begin
                if (i_CPU_WE) begin
                    sh[i_CPU_ADDR]  = i_CPU_DIN;
                    shw[i_CPU_ADDR] = 1'b1;
                    e.d = m_dout;
                end else begin
                    e.d = sh_rd(i_CPU_ADDR);
                    m_dout = e.d;
                end
                e.due = cyc + 2;
                cq.push_back(e);
                m_idle = 1'b0;
                m_free = cyc + 4;
            end
            if (!pend || cgr) m_starve = 0;
            else if (m_starve < 255) m_starve++;
        end
    end

    // Monitor: compares DUT outputs against the scoreboard mid-cycle
    bit   prev_wr_low = 1'b0;
    exp_t got;
    always @(negedge clk) begin
        if (rst) begin
            prev_wr_low = 1'b0;
        end else begin
            chk("vid_rdy", o_VID_RDY, !(GUARD && m_idle && i_CPU_REQ && (m_starve == LIMIT)));
            if (!o_RAM_WR_n || !o_RAM_RD_n) chk("strobe_excl", !o_RAM_WR_n && !o_RAM_RD_n, 0);
            if (!o_RAM_WR_n) chk("wr_single_cycle", prev_wr_low, 0);
            prev_wr_low = !o_RAM_WR_n;
            if (o_VID_VALID) begin
                if (vq.size() == 0) chk("vid_spurious", 1, 0);
                else begin
                    got = vq.pop_front();
                    chk("vid_data", o_VID_DATA, got.d);
                    chk("vid_latency", cyc, got.due);
                end
            end else if (vq.size() > 0 && vq[0].due <= cyc) begin
                chk("vid_missing", 0, 1);
                void'(vq.pop_front());
            end
            if (o_CPU_ACK) begin
                if (cq.size() == 0) chk("cpu_ack_spurious", 1, 0);
                else begin
                    got = cq.pop_front();
                    chk("cpu_dout", o_CPU_DOUT, got.d);
                    chk("cpu_latency", cyc, got.due);
                end
            end else if (cq.size() > 0 && cq[0].due <= cyc) begin
                chk("cpu_ack_missing", 0, 1);
                void'(cq.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_reset_vals();
        chk("rst_wr_n", o_RAM_WR_n, 1);
        chk("rst_rd_n", o_RAM_RD_n, 1);
        chk("rst_addr", o_RAM_ADDR, 0);
        chk("rst_din", o_RAM_DIN, 0);
        chk("rst_vid_data", o_VID_DATA, 0);
        chk("rst_vid_valid", o_VID_VALID, 0);
        chk("rst_cpu_dout", o_CPU_DOUT, 0);
        chk("rst_cpu_ack", o_CPU_ACK, 0);
    endtask

    task automatic wait_ack();
        int n = 0;
        while (!o_CPU_ACK && n < 60) begin
            step(1);
            n++;
        end
        if (!o_CPU_ACK) chk("cpu_ack_timeout", 0, 1);
    endtask

    task automatic cpu_do(input bit we, input logic [11:0] a, input logic [7:0] d);
        i_CPU_REQ = 1'b1; i_CPU_WE = we; i_CPU_ADDR = a; i_CPU_DIN = d;
        wait_ack();
        step(2);
        i_CPU_REQ = 1'b0;
        step(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        bit acked;
        int hold;
        int cool;
        #1 rst = 1'b1;
        #1 check_reset_vals();
        #20 rst = 1'b0;
        step(2);

        // video burst over preloaded words
        for (int i = 0; i < 3; i++) begin
            i_VID_REQ = 1'b1; i_VID_ADDR = 12'(i);
            step(1);
        end
        i_VID_REQ = 1'b0;
        step(4);

        // write then read back the top address
        cpu_do(1'b1, 12'hFFF, 8'h5A);
        cpu_do(1'b0, 12'hFFF, 8'h00);

        // simultaneous requests: video first, CPU next edge
        i_VID_REQ = 1'b1; i_VID_ADDR = 12'h010;
        i_CPU_REQ = 1'b1; i_CPU_WE = 1'b0; i_CPU_ADDR = 12'h020;
        step(1);
        i_VID_REQ = 1'b0;
        wait_ack();
        i_CPU_REQ = 1'b0;
        step(3);

        // continuous video against a waiting CPU
        i_CPU_REQ = 1'b1; i_CPU_WE = 1'b0; i_CPU_ADDR = 12'h005;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            i_VID_REQ = 1'b1; i_VID_ADDR = 12'($urandom_range(0, 4095));
            step(1);
            if (o_CPU_ACK) seen = 1'b1;
        end
        chk("starve_ack_seen", seen, GUARD);
        i_VID_REQ = 1'b0;
        if (!seen) wait_ack();
        i_CPU_REQ = 1'b0;
        step(3);

        // reset while the CPU access is in WAIT; REQ stays held through it
        i_CPU_REQ = 1'b1; i_CPU_WE = 1'b0; i_CPU_ADDR = 12'h021;
        step(2);
        rst = 1'b1;
        #1 check_reset_vals();
        step(1);
        rst = 1'b0;
        wait_ack();
        i_CPU_REQ = 1'b0;
        step(3);

        // random traffic
        acked = 1'b0; hold = 0; cool = 0;
        for (int i = 0; i < 400; i++) begin
            i_VID_REQ  = ($urandom_range(0, 3) != 0);
            i_VID_ADDR = 12'($urandom_range(0, 31));
            if (i_CPU_REQ) begin
                if (!acked && o_CPU_ACK) begin
                    acked = 1'b1;
                    hold  = $urandom_range(0, 2);
                end
                if (acked) begin
                    if (hold == 0) begin
                        i_CPU_REQ = 1'b0;
                        acked = 1'b0;
                        cool = 2;
                    end else hold--;
                end
            end else if (cool > 0) begin
                cool--;
            end else if ($urandom_range(0, 2) == 0) begin
                i_CPU_REQ  = 1'b1;
                i_CPU_WE   = 1'($urandom_range(0, 1));
                i_CPU_ADDR = 12'($urandom_range(0, 31));
                i_CPU_DIN  = 8'($urandom_range(0, 255));
            end
            step(1);
        end
        i_VID_REQ = 1'b0;
        if (i_CPU_REQ && !acked) wait_ack();
        i_CPU_REQ = 1'b0;
        step(10);

        chk("vid_queue_drained", vq.size(), 0);
        chk("cpu_queue_drained", cq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
